// File: rtl/lbus_pkg.sv
// Shared types and helpers for the AXIS-to-LBUS transmit path.
// Segment count and byte width are fixed by the 100G CMAC LBUS port.
package lbus_pkg;

    localparam int SEG_NUM   = 4;
    localparam int SEG_BYTES = 16;

    typedef struct packed {
        logic [127:0] data;
        logic         ena;
        logic         sop;
        logic         eop;
        logic         err;
        logic [3:0]   mty;
    } lbus_seg_t;

    // Number of valid bytes in a 64-byte beat; 0..64 needs 7 bits.
    function automatic logic [6:0] keep_popcnt(input logic [63:0] keep);
        logic [6:0] cnt;
        cnt = '0;
        for (int i = 0; i < 64; i++) begin
            cnt = cnt + 7'(keep[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/lbus_seg_enc.sv
// Combinational encoder for one 16-byte LBUS segment.
// Reverses byte order and derives ENA/SOP/EOP/ERR/MTY from the beat byte count.
module lbus_seg_enc
    import lbus_pkg::*;
(
    input  logic [127:0] slice,
    input  logic [1:0]   seg_idx,
    input  logic [6:0]   n,
    input  logic         last,
    input  logic         err,
    input  logic         sop,
    output lbus_seg_t    seg
);

    logic [127:0] rev;
    logic [1:0]   last_seg;
    logic         ena;

    // AXIS byte 0 of the slice lands in the most significant LBUS byte.
    generate
        for (genvar gi = 0; gi < SEG_BYTES; gi++) begin : g_rev
            assign rev[8*(SEG_BYTES-1-gi) +: 8] = slice[8*gi +: 8];
        end
    endgenerate

    // n is already forced into 1..64, so the last segment is ceil(n/16)-1.
    assign last_seg = (n > 7'd48) ? 2'd3 :
                      (n > 7'd32) ? 2'd2 :
                      (n > 7'd16) ? 2'd1 : 2'd0;

    assign ena = !last || (seg_idx <= last_seg);

    always_comb begin
        seg      = '0;
        seg.ena  = ena;
        seg.data = ena ? rev : '0;
        seg.sop  = sop && (seg_idx == 2'd0);
        if (last && (seg_idx == last_seg)) begin
            seg.eop = 1'b1;
            seg.err = err;
            seg.mty = 4'd0 - n[3:0];
        end
    end

endmodule

// File: rtl/axis_lbus_tx.sv
// 512-bit AXI4-Stream to 4x128-bit CMAC LBUS transmit converter, one registered cycle per beat.
// Define AXIS_LBUS_TX_ERR_EN to add s_axis_tuser and drive tx_errin on the EOP segment.
module axis_lbus_tx #(
    parameter int SEG_NUM   = 4,
    parameter int PKT_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [511:0]           s_axis_tdata,
    input  logic [63:0]            s_axis_tkeep,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tvalid,
`ifdef AXIS_LBUS_TX_ERR_EN
    input  logic                   s_axis_tuser,
`endif
    output logic                   s_axis_tready,
    input  logic                   tx_rdy,
    input  logic                   tx_ovfout,
    input  logic                   tx_unfout,
    output logic [511:0]           tx_datain,
    output logic [SEG_NUM-1:0]     tx_enain,
    output logic [SEG_NUM-1:0]     tx_sopin,
    output logic [SEG_NUM-1:0]     tx_eopin,
    output logic [SEG_NUM-1:0]     tx_errin,
    output logic [4*SEG_NUM-1:0]   tx_mtyin,
    output logic                   stat_unf,
    output logic                   stat_ovf,
    output logic                   stat_keep_err,
    output logic [PKT_CNT_W-1:0]   pkt_cnt
);

    import lbus_pkg::*;

    typedef enum logic {
        ST_IDLE,
        ST_IN_PKT
    } state_t;

    state_t                 state_reg;
    logic                   accept;
    logic [6:0]             keep_cnt;
    logic                   keep_zero;
    logic [6:0]             n_eff;
    logic                   keep_bad;
    logic                   user_err;
    logic                   sop_beat;
    logic                   underflow;

    lbus_seg_t              seg_next [SEG_NUM];
    logic [511:0]           data_next;
    logic [SEG_NUM-1:0]     ena_next;
    logic [SEG_NUM-1:0]     sop_next;
    logic [SEG_NUM-1:0]     eop_next;
    logic [SEG_NUM-1:0]     err_next;
    logic [4*SEG_NUM-1:0]   mty_next;

    generate
        if (SEG_NUM != 4) begin : g_seg_num_check
            $error("axis_lbus_tx: SEG_NUM must be 4");
        end
    endgenerate

    assign s_axis_tready = tx_rdy;
    assign accept        = s_axis_tvalid & tx_rdy;

    assign keep_cnt  = keep_popcnt(s_axis_tkeep);
    assign keep_zero = (keep_cnt == 7'd0);
    // An empty last beat is sent as a full one so the packet still terminates.
    assign n_eff     = keep_zero ? 7'd64 : keep_cnt;
    assign keep_bad  = s_axis_tlast ? keep_zero : (s_axis_tkeep != {64{1'b1}});

`ifdef AXIS_LBUS_TX_ERR_EN
    assign user_err = s_axis_tuser;
`else
    assign user_err = 1'b0;
`endif

    assign sop_beat  = (state_reg == ST_IDLE);
    assign underflow = (state_reg == ST_IN_PKT) && tx_rdy && !s_axis_tvalid;

    generate
        for (genvar gi = 0; gi < SEG_NUM; gi++) begin : g_seg
            lbus_seg_enc u_enc (
                .slice   (s_axis_tdata[128*gi +: 128]),
                .seg_idx (2'(gi)),
                .n       (n_eff),
                .last    (s_axis_tlast),
                .err     (user_err),
                .sop     (sop_beat),
                .seg     (seg_next[gi])
            );

            assign data_next[128*gi +: 128] = seg_next[gi].data;
            assign ena_next[gi]             = seg_next[gi].ena;
            assign sop_next[gi]             = seg_next[gi].sop;
            assign eop_next[gi]             = seg_next[gi].eop;
            assign err_next[gi]             = seg_next[gi].err;
            assign mty_next[4*gi +: 4]      = seg_next[gi].mty;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            tx_datain     <= '0;
            tx_enain      <= '0;
            tx_sopin      <= '0;
            tx_eopin      <= '0;
            tx_errin      <= '0;
            tx_mtyin      <= '0;
            stat_unf      <= 1'b0;
            stat_ovf      <= 1'b0;
            stat_keep_err <= 1'b0;
            pkt_cnt       <= '0;
        end else begin
            if (accept) begin
                tx_datain <= data_next;
                tx_enain  <= ena_next;
                tx_sopin  <= sop_next;
                tx_eopin  <= eop_next;
                tx_errin  <= err_next;
                tx_mtyin  <= mty_next;
                if (s_axis_tlast) begin
                    state_reg <= ST_IDLE;
                    pkt_cnt   <= pkt_cnt + PKT_CNT_W'(1);
                end else begin
                    state_reg <= ST_IN_PKT;
                end
            end else begin
                // Data is left as-is on idle cycles; only the qualifiers drop.
                tx_enain <= '0;
                tx_sopin <= '0;
                tx_eopin <= '0;
                tx_errin <= '0;
                tx_mtyin <= '0;
            end

            if (tx_unfout || underflow) begin
                stat_unf <= 1'b1;
            end
            if (tx_ovfout) begin
                stat_ovf <= 1'b1;
            end
            if (accept && keep_bad) begin
                stat_keep_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_lbus_tx.sv
// Scoreboard bench for axis_lbus_tx: directed packets push expected LBUS cycles,
// a negedge monitor pops and compares whenever the DUT enables any segment.
module tb_axis_lbus_tx;

`ifdef AXIS_LBUS_TX_ERR_EN
    localparam logic ERR_BIT = 1'b1;
`else
    localparam logic ERR_BIT = 1'b0;
`endif

    typedef struct {
        logic [511:0] data;
        logic [3:0]   ena;
        logic [3:0]   sop;
        logic [3:0]   eop;
        logic [3:0]   err;
        logic [15:0]  mty;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] s_axis_tdata;
    logic [63:0]  s_axis_tkeep;
    logic         s_axis_tlast;
    logic         s_axis_tvalid;
    logic         s_axis_tuser;
    logic         s_axis_tready;
    logic         tx_rdy;
    logic         tx_ovfout;
    logic         tx_unfout;
    logic [511:0] tx_datain;
    logic [3:0]   tx_enain;
    logic [3:0]   tx_sopin;
    logic [3:0]   tx_eopin;
    logic [3:0]   tx_errin;
    logic [15:0]  tx_mtyin;
    logic         stat_unf;
    logic         stat_ovf;
    logic         stat_keep_err;
    logic [31:0]  pkt_cnt;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    axis_lbus_tx #(.SEG_NUM(4), .PKT_CNT_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
`ifdef AXIS_LBUS_TX_ERR_EN
        .s_axis_tuser  (s_axis_tuser),
`endif
        .s_axis_tready (s_axis_tready),
        .tx_rdy        (tx_rdy),
        .tx_ovfout     (tx_ovfout),
        .tx_unfout     (tx_unfout),
        .tx_datain     (tx_datain),
        .tx_enain      (tx_enain),
        .tx_sopin      (tx_sopin),
        .tx_eopin      (tx_eopin),
        .tx_errin      (tx_errin),
        .tx_mtyin      (tx_mtyin),
        .stat_unf      (stat_unf),
        .stat_ovf      (stat_ovf),
        .stat_keep_err (stat_keep_err),
        .pkt_cnt       (pkt_cnt)
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Expected LBUS data: each enabled segment holds its 16 AXIS bytes in reverse order.
    function automatic logic [511:0] model_data(input logic [511:0] d, input logic [3:0] ena);
        logic [511:0] r;
        r = '0;
        for (int s = 0; s < 4; s++) begin
            for (int j = 0; j < 16; j++) begin
                if (ena[s]) r[128*s + 8*(15-j) +: 8] = d[8*(16*s+j) +: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [511:0] pattern(input int seed);
        logic [511:0] r;
        for (int k = 0; k < 64; k++) r[8*k +: 8] = 8'(k*3 + seed);
        return r;
    endfunction

    task automatic send_beat(input logic [511:0] d, input logic [63:0] keep, input logic last,
                             input logic user, input logic [3:0] ena, input logic [3:0] sop,
                             input logic [3:0] eop, input logic [3:0] err, input logic [15:0] mty);
        exp_t e;
        int   waited;
        logic acc;
        waited = 0;
        acc    = 1'b0;
        s_axis_tdata  = d;
        s_axis_tkeep  = keep;
        s_axis_tlast  = last;
        s_axis_tuser  = user;
        s_axis_tvalid = 1'b1;
        while (!acc && waited < 50) begin
            @(posedge clk);
            if (tx_rdy) begin
                acc    = 1'b1;
                e.data = model_data(d, ena);
                e.ena  = ena;
                e.sop  = sop;
                e.eop  = eop;
                e.err  = err;
                e.mty  = mty;
                q.push_back(e);
            end
            waited++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no acceptance in %0d cycles", waited);
        end
        #1;
        if (last) s_axis_tvalid = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (tx_enain !== 4'h0) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got ena=%0h want no output", tx_enain);
                end else begin
                    e = q.pop_front();
                    chk("mon_data", tx_datain, e.data);
                    chk("mon_ena", tx_enain, e.ena);
                    chk("mon_sop", tx_sopin, e.sop);
                    chk("mon_eop", tx_eopin, e.eop);
                    chk("mon_err", tx_errin, e.err);
                    chk("mon_mty", tx_mtyin, e.mty);
                end
            end else begin
                chk("idle_flags", {tx_sopin, tx_eopin, tx_errin, tx_mtyin}, 28'h0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] d;
        logic [511:0] d2;

        rst           = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        tx_rdy        = 1'b1;
        tx_ovfout     = 1'b0;
        tx_unfout     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        chk("rst_data", tx_datain, 512'h0);
        chk("rst_flags", {tx_enain, tx_sopin, tx_eopin, tx_errin, tx_mtyin}, 32'h0);
        chk("rst_stat", {stat_unf, stat_ovf, stat_keep_err}, 3'b000);
        chk("rst_pkt_cnt", pkt_cnt, 32'd0);
        chk("tready_follows_rdy", s_axis_tready, 1'b1);

        // 64-byte single-beat packet
        send_beat(pattern(1), {64{1'b1}}, 1'b1, 1'b0, 4'hF, 4'h1, 4'h8, 4'h0, 16'h0000);
        chk("pkt64_cnt", pkt_cnt, 32'd1);

        // 65-byte packet: tail is one byte in segment 0
        send_beat(pattern(2), {64{1'b1}}, 1'b0, 1'b0, 4'hF, 4'h1, 4'h0, 4'h0, 16'h0000);
        d = pattern(3);
        send_beat(d, 64'h1, 1'b1, 1'b0, 4'h1, 4'h0, 4'h1, 4'h0, 16'h000F);
        chk("pkt65_byte64", tx_datain[127:120], d[7:0]);
        chk("pkt65_cnt", pkt_cnt, 32'd2);

        // 100-byte packet: tail of 36 bytes ends in segment 2 with MTY 12
        send_beat(pattern(4), {64{1'b1}}, 1'b0, 1'b0, 4'hF, 4'h1, 4'h0, 4'h0, 16'h0000);
        send_beat(pattern(5), 64'h0000_000F_FFFF_FFFF, 1'b1, 1'b0, 4'h7, 4'h0, 4'h4, 4'h0, 16'h0C00);
        chk("pkt100_cnt", pkt_cnt, 32'd3);

        // 48-byte single beat: exact segment boundary, MTY 0 in segment 2
        send_beat(pattern(6), 64'h0000_FFFF_FFFF_FFFF, 1'b1, 1'b0, 4'h7, 4'h1, 4'h4, 4'h0, 16'h0000);

        // 4-beat packet with tx_rdy low for 3 cycles while tvalid is held
        fork
            begin
                send_beat(pattern(7), {64{1'b1}}, 1'b0, 1'b0, 4'hF, 4'h1, 4'h0, 4'h0, 16'h0000);
                send_beat(pattern(8), {64{1'b1}}, 1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000);
                send_beat(pattern(9), {64{1'b1}}, 1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000);
                send_beat(pattern(10), {64{1'b1}}, 1'b1, 1'b0, 4'hF, 4'h0, 4'h8, 4'h0, 16'h0000);
            end
            begin
                repeat (2) @(negedge clk);
                tx_rdy = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("stall_tready", s_axis_tready, 1'b0);
                    chk("stall_no_ena", tx_enain, 4'h0);
                end
                tx_rdy = 1'b1;
            end
        join
        chk("stall_no_unf", stat_unf, 1'b0);
        chk("stall_pkt_cnt", pkt_cnt, 32'd5);

        // tvalid gap mid-packet with tx_rdy high is an underflow
        send_beat(pattern(11), {64{1'b1}}, 1'b0, 1'b0, 4'hF, 4'h1, 4'h0, 4'h0, 16'h0000);
        s_axis_tvalid = 1'b0;
        cycle();
        chk("unf_set", stat_unf, 1'b1);
        repeat (3) cycle();
        chk("unf_sticky", stat_unf, 1'b1);
        chk("no_keep_err_yet", stat_keep_err, 1'b0);

        // reset mid-packet together with an overflow pulse: reset wins
        rst       = 1'b1;
        tx_ovfout = 1'b1;
        cycle();
        rst       = 1'b0;
        tx_ovfout = 1'b0;
        chk("rst_clears_unf", stat_unf, 1'b0);
        chk("rst_beats_ovf", stat_ovf, 1'b0);
        chk("rst_clears_cnt", pkt_cnt, 32'd0);
        send_beat(pattern(12), {64{1'b1}}, 1'b1, 1'b0, 4'hF, 4'h1, 4'h8, 4'h0, 16'h0000);
        chk("post_rst_cnt", pkt_cnt, 32'd1);

        // CMAC status pulses
        tx_ovfout = 1'b1;
        cycle();
        tx_ovfout = 1'b0;
        chk("ovf_set", stat_ovf, 1'b1);
        chk("ovf_no_unf", stat_unf, 1'b0);
        tx_unfout = 1'b1;
        cycle();
        tx_unfout = 1'b0;
        cycle();
        chk("unfout_set", stat_unf, 1'b1);
        chk("ovf_sticky", stat_ovf, 1'b1);

        // tkeep=0 on a last beat is sent as 64 bytes and flagged
        send_beat(pattern(13), 64'h0, 1'b1, 1'b0, 4'hF, 4'h1, 4'h8, 4'h0, 16'h0000);
        chk("keep0_err", stat_keep_err, 1'b1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("keep_err_rst", stat_keep_err, 1'b0);

        // short keep on a non-last beat still sends all 64 bytes
        send_beat(pattern(14), 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 4'hF, 4'h1, 4'h0, 4'h0, 16'h0000);
        chk("keep_short_err", stat_keep_err, 1'b1);
        send_beat(pattern(15), 64'h0000_0000_0000_FFFF, 1'b1, 1'b0, 4'h1, 4'h0, 4'h1, 4'h0, 16'h0000);

        // 130-byte packet with tuser on a middle beat (ignored) and on the last beat
        send_beat(pattern(16), {64{1'b1}}, 1'b0, 1'b0, 4'hF, 4'h1, 4'h0, 4'h0, 16'h0000);
        send_beat(pattern(17), {64{1'b1}}, 1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000);
        d2 = pattern(18);
        send_beat(d2, 64'h3, 1'b1, 1'b1, 4'h1, 4'h0, 4'h1, {3'b000, ERR_BIT}, 16'h000E);
        chk("pkt130_byte1", tx_datain[119:112], d2[15:8]);
        chk("pkt130_cnt", pkt_cnt, 32'd2);

        repeat (3) cycle();
        chk("queue_drained", 512'(q.size()), 512'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_lbus_tx.md
# axis_lbus_tx

Transmit-side converter from a 512-bit AXI4-Stream packet interface to the 4-segment, 128-bit-per-segment LBUS transmit interface of the 100G CMAC. It sits between the user/stack TX datapath and the CMAC `tx_*` LBUS port, and complements the LBUS-to-AXIS receive path. Each accepted AXIS beat becomes one registered LBUS cycle, with per-segment byte reversal, SOP/EOP/MTY/ENA generation and sticky error status.

## Interface
- `SEG_NUM`, 4: number of LBUS segments; fixed at 4 and checked by elaboration assertion.
- `PKT_CNT_W`, 32: width of the transmitted-packet counter.
- `clk` in 1: CMAC TX user clock.
- `rst` in 1: reset, synchronous, active-high.
- `s_axis_tdata` in 512: byte k at bits [8k+7:8k].
- `s_axis_tkeep` in 64: byte enables, contiguous from byte 0.
- `s_axis_tlast` in 1: last beat of packet.
- `s_axis_tvalid` in 1; `s_axis_tready` out 1.
- `s_axis_tuser` in 1: packet error; present only with `AXIS_LBUS_TX_ERR_EN`.
- `tx_rdy` in 1: CMAC ready.
- `tx_ovfout` in 1; `tx_unfout` in 1: CMAC overflow/underflow pulses.
- `tx_datain` out 512: segment i at [128i+127:128i].
- `tx_enain`, `tx_sopin`, `tx_eopin`, `tx_errin` out 4 each: per-segment flags, bit i = segment i.
- `tx_mtyin` out 16: segment i MTY at [4i+3:4i].
- `stat_unf`, `stat_ovf`, `stat_keep_err` out 1 each: sticky flags.
- `pkt_cnt` out `PKT_CNT_W`: number of EOPs emitted.

## Operation
- `s_axis_tready = tx_rdy` (combinational). A beat is accepted when `s_axis_tvalid & tx_rdy`.
- Segment i carries AXIS bytes 16i..16i+15, byte-reversed: AXIS byte 16i goes to `tx_datain[128i+127:128i+120]`.
- Two-state FSM:
  - IDLE goes to IN_PKT on an accepted beat with `tlast=0`.
  - IN_PKT goes to IDLE on an accepted beat with `tlast=1`.
  - A single-beat packet stays in IDLE.
- `tx_sopin[0]=1` on an accepted beat taken in IDLE; all other SOP bits are always 0.
- Non-last beat:
  - `tx_enain=4'hF`, `eop=0`, `mty=0`.
  - `tkeep` must be all ones; otherwise set `stat_keep_err` and still transmit 64 bytes.
- Last beat, N = popcount(`tkeep`):
  - If N=0, set `stat_keep_err` and treat the beat as N=64.
  - L = ceil(N/16)-1.
  - ENA bits 0..L are set.
  - `tx_eopin[L]=1`.
  - `tx_mtyin[L] = (16 - N mod 16) mod 16`.
  - All other MTY fields are 0.
- Data in disabled segments is zeroed.
- Cycle with no accepted beat: all ENA/SOP/EOP/ERR/MTY are 0, and data holds its previous value.
- Underflow: in IN_PKT with `tx_rdy=1` and `s_axis_tvalid=0`, set `stat_unf`. `tx_unfout=1` also sets `stat_unf`. `tx_ovfout=1` sets `stat_ovf`.
- Sticky flags clear only on `rst`.
- `pkt_cnt` increments by 1 per emitted EOP and wraps modulo 2^`PKT_CNT_W`.

## Timing
- Latency is 1 cycle: a beat accepted at edge n appears on `tx_*` after edge n.
- All `tx_*` and `stat_*` outputs and `pkt_cnt` are registered.
- Reset values:
  - All `tx_*` outputs are 0.
  - `stat_*` = 0 and `pkt_cnt` = 0.
  - FSM = IDLE.
- `tx_rdy` deasserting blocks acceptance in that same cycle. This relies on CMAC absorbing the already-registered cycle.
- `rst` mid-packet:
  - The FSM returns to IDLE and no EOP is emitted for the truncated packet.
  - The next accepted beat is treated as SOP.
- When a sticky-set event and `rst` occur in the same cycle, `rst` wins.

## Configuration
- `AXIS_LBUS_TX_ERR_EN` defined:
  - `s_axis_tuser` exists.
  - `tuser=1` on an accepted last beat sets `tx_errin[L]` alongside EOP.
  - `tuser` on non-last beats is ignored.
- Not defined: the `s_axis_tuser` port is absent and `tx_errin` is constant 0.

## Structure
- Package `lbus_pkg`:
  - `SEG_NUM`, `SEG_BYTES=16`.
  - Typedef `lbus_seg_t` with fields data[127:0], ena, sop, eop, err, mty[3:0].
  - Function `keep_popcnt`.
- Sub-module `lbus_seg_enc`, instantiated `SEG_NUM` times, is combinational per segment. It takes the 16-byte slice, the segment index, N, last, err and sop, and produces the byte-reversed data plus that segment's ENA/EOP/MTY/ERR/SOP.
- The top level holds the FSM, output registers, status logic and counter.

## Test plan
- 64-byte packet (one beat, `tkeep`=all ones, `tlast=1`): one cycle with `enain=F`, `sopin=1`, `eopin=8`, `mty=0`, `pkt_cnt=1`.
- 65-byte packet (beat 1 full, beat 2 `tkeep=64'h1`): cycle 2 has `enain=1`, `eopin=1`, `mty[3:0]=15`, and AXIS byte 64 appears at `tx_datain[127:120]`.
- 100-byte packet: cycle 2 has N=36, `enain=7`, `eopin=4`, `mty[11:8]=12`; `sopin` is 0 on cycle 2.
- Deassert `tx_rdy` for 3 cycles during a 4-beat packet with `tvalid` held: `tready` is low for those 3 cycles, no ENA is issued, all 4 beats are delivered in order, and `stat_unf=0`.
- Drop `tvalid` mid-packet with `tx_rdy=1`: `stat_unf=1`, which stays set until `rst`. Then pulse `rst` mid-packet: the next beat carries SOP.
- With `AXIS_LBUS_TX_ERR_EN` and a 130-byte packet with `tuser=1` on the last beat: the final cycle has `errin=1` and `eopin=1` on segment 0, `mty=14`. Also drive `tkeep=0` with `tlast=1`: `stat_keep_err=1` and `enain=F`.
